// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vga_timing_ctrl                                            |
// | Description : VGA raster sequencer. Owns the horizontal/vertical pixel   |
// |               counters and their active/front-porch/sync/back-porch      |
// |               phases. Produces active-low syncs, video_on, pixel         |
// |               coordinates and line/frame pulses. The raster starts on    |
// |               en and always finishes the current frame before stopping.  |
// |               Optional macro VGA_PIXEL_DIV2_EN: pixel tick every second  |
// |               clk (e.g. 25 MHz pixels from a 50 MHz clk).                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_end,
  output logic          frame_end,
  output logic          running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last counter index of each phase; a phase hands over on the tick
  // where its counter sits on that index.
  localparam logic [CW-1:0] C_H_ACT_LAST  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] C_H_FP_LAST   = CW'(H_ACTIVE + H_FP - 1);
  localparam logic [CW-1:0] C_H_SYNC_LAST = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] C_H_LAST      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] C_V_ACT_LAST  = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] C_V_FP_LAST   = CW'(V_ACTIVE + V_FP - 1);
  localparam logic [CW-1:0] C_V_SYNC_LAST = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] C_V_LAST      = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] C_ONE         = CW'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  typedef enum logic [1:0] {
    PH_ACT  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_e;

  run_state_e    state_q, state_d;
  phase_e        hph_q, hph_d;
  phase_e        vph_q, vph_d;
  logic [CW-1:0] hcount_q, hcount_d;
  logic [CW-1:0] vcount_q, vcount_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic          line_end_q, line_end_d;
  logic          frame_end_q, frame_end_d;

  logic          w_tick;        // pixel tick in the current clk
  logic          w_tick_next;   // pixel tick in the following clk
  logic          w_line_wrap;
  logic          w_frame_wrap;

`ifdef VGA_PIXEL_DIV2_EN
  logic toggle_q, toggle_d;

  // Divide-by-two pixel enable; parked at 0 outside RUN so the first
  // advance lands on the second clk after entering RUN.
  always_comb begin
    toggle_d = 1'b0;
    if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
      toggle_d = ~toggle_q;
    end
  end

  // Toggle register.
  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_q <= 1'b0;
    end else begin
      toggle_q <= toggle_d;
    end
  end

  assign w_tick      = (state_q == ST_RUN) && toggle_q;
  assign w_tick_next = toggle_d;
`else
  assign w_tick      = (state_q == ST_RUN);
  assign w_tick_next = (state_d == ST_RUN);
`endif

  assign w_line_wrap  = w_tick && (hcount_q == C_H_LAST);
  assign w_frame_wrap = w_line_wrap && (vcount_q == C_V_LAST);

  // Run FSM next state: start immediately, stop only on a frame boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN:  if (w_frame_wrap && !en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter and phase next state; everything parks at zero/ACT in IDLE.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    hph_d    = hph_q;
    vph_d    = vph_q;
    if (state_d == ST_IDLE) begin
      hcount_d = '0;
      vcount_d = '0;
      hph_d    = PH_ACT;
      vph_d    = PH_ACT;
    end else if (w_tick) begin
      hcount_d = w_line_wrap ? '0 : (hcount_q + C_ONE);
      case (hph_q)
        PH_ACT:  if (hcount_q == C_H_ACT_LAST)  hph_d = PH_FP;
        PH_FP:   if (hcount_q == C_H_FP_LAST)   hph_d = PH_SYNC;
        PH_SYNC: if (hcount_q == C_H_SYNC_LAST) hph_d = PH_BP;
        PH_BP:   if (w_line_wrap)               hph_d = PH_ACT;
        default: hph_d = PH_ACT;
      endcase
      if (w_line_wrap) begin
        vcount_d = (vcount_q == C_V_LAST) ? '0 : (vcount_q + C_ONE);
        case (vph_q)
          PH_ACT:  if (vcount_q == C_V_ACT_LAST)  vph_d = PH_FP;
          PH_FP:   if (vcount_q == C_V_FP_LAST)   vph_d = PH_SYNC;
          PH_SYNC: if (vcount_q == C_V_SYNC_LAST) vph_d = PH_BP;
          PH_BP:   if (vcount_q == C_V_LAST)      vph_d = PH_ACT;
          default: vph_d = PH_ACT;
        endcase
      end
    end
  end

  // Output decode from next-state values so registered outputs line up
  // with the counters they describe.
  always_comb begin
    hsync_d     = (hph_d != PH_SYNC);
    vsync_d     = (vph_d != PH_SYNC);
    video_on_d  = (state_d == ST_RUN) && (hph_d == PH_ACT) && (vph_d == PH_ACT);
    x_d         = video_on_d ? hcount_d : '0;
    y_d         = video_on_d ? vcount_d : '0;
    line_end_d  = (state_d == ST_RUN) && w_tick_next && (hcount_d == C_H_LAST);
    frame_end_d = line_end_d && (vcount_d == C_V_LAST);
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hph_q       <= PH_ACT;
      vph_q       <= PH_ACT;
      hcount_q    <= '0;
      vcount_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      video_on_q  <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hph_q       <= hph_d;
      vph_q       <= vph_d;
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      video_on_q  <= video_on_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign hcount    = hcount_q;
  assign vcount    = vcount_q;
  assign x         = x_q;
  assign y         = y_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign video_on  = video_on_q;
  assign line_end  = line_end_q;
  assign frame_end = frame_end_q;
  assign running   = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_vga_timing_ctrl                                         |
// | Description : Scoreboard bench for vga_timing_ctrl on a shrunken raster  |
// |               (16 x 9). Expected snapshots are queued by the stimulus;   |
// |               a monitor compares them on the falling edge.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_vga_timing_ctrl;

  localparam int TA = 8, TF = 2, TS = 3, TB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 2;
  localparam int HT = TA + TF + TS + TB;   // 16
  localparam int VT = VA + VF + VS + VB;   // 9
  localparam int FR = HT * VT;             // 144 pixels per frame
`ifdef VGA_PIXEL_DIV2_EN
  localparam int DK = 2;
`else
  localparam int DK = 1;
`endif

  logic       clk, rst, en;
  logic [9:0] hcount, vcount, x, y;
  logic       hsync, vsync, video_on, line_end, frame_end, running;

  vga_timing_ctrl #(
    .H_ACTIVE(TA), .H_FP(TF), .H_SYNC(TS), .H_BP(TB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CW(10)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .hcount(hcount), .vcount(vcount), .x(x), .y(y),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .line_end(line_end), .frame_end(frame_end), .running(running)
  );

  typedef struct {
    int         cyc;
    int         kind;   // 0 snapshot, 1 window counts, 2 clear counts
    string      nm;
    logic [9:0] h, v, x, y;
    logic       hs, vs, vo, le, fe, run;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  int   le_cnt = 0, fe_cnt = 0, hs_cnt = 0, vs_cnt = 0, vo_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cyc=%0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  // Expected outputs while running, k clks after RUN entry.
  function automatic exp_t run_exp(int c, int k, string nm);
    exp_t e;
    int   p, h, v;
    bit   tk;
    p     = k / DK;
    tk    = (DK == 1) || (k % 2 == 1);
    h     = p % HT;
    v     = (p / HT) % VT;
    e.cyc = c; e.kind = 0; e.nm = nm;
    e.h   = 10'(h);
    e.v   = 10'(v);
    e.hs  = !((h >= TA + TF) && (h < TA + TF + TS));
    e.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
    e.vo  = (h < TA) && (v < VA);
    e.x   = e.vo ? e.h : 10'd0;
    e.y   = e.vo ? e.v : 10'd0;
    e.le  = tk && (h == HT - 1);
    e.fe  = e.le && (v == VT - 1);
    e.run = 1'b1;
    return e;
  endfunction

  function automatic exp_t idle_exp(int c, string nm);
    exp_t e;
    e.cyc = c; e.kind = 0; e.nm = nm;
    e.h = '0; e.v = '0; e.x = '0; e.y = '0;
    e.hs = 1'b1; e.vs = 1'b1; e.vo = 1'b0; e.le = 1'b0; e.fe = 1'b0; e.run = 1'b0;
    return e;
  endfunction

  task automatic push_run(int base, int p, string nm);
    for (int s = 0; s < DK; s++) sbq.push_back(run_exp(base + p * DK + s, p * DK + s, nm));
  endtask

  task automatic push_idle(int c, string nm);
    sbq.push_back(idle_exp(c, nm));
  endtask

  task automatic push_ctl(int c, int kind, string nm);
    exp_t e;
    e = idle_exp(c, nm);
    e.kind = kind;
    sbq.push_back(e);
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string nm, int act, int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Monitor: accumulate pulse/level counts and retire due snapshots.
  always @(negedge clk) begin
    exp_t e;
    if (line_end === 1'b1)  le_cnt++;
    if (frame_end === 1'b1) fe_cnt++;
    if (hsync === 1'b0)     hs_cnt++;
    if (vsync === 1'b0)     vs_cnt++;
    if (video_on === 1'b1)  vo_cnt++;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      if (e.cyc < cyc) begin
        n_checks++; n_err++;
        $display("FAIL %s: missed at cyc %0d, required cyc %0d", e.nm, cyc, e.cyc);
      end else if (e.kind == 1) begin
        chk("line_end_count", le_cnt, VT);
        chk("frame_end_count", fe_cnt, 1);
        chk("hsync_low_clks", hs_cnt, VT * TS * DK);
        chk("vsync_low_clks", vs_cnt, VS * HT * DK);
        chk("video_on_clks", vo_cnt, TA * VA * DK);
      end else if (e.kind == 2) begin
        le_cnt = 0; fe_cnt = 0; hs_cnt = 0; vs_cnt = 0; vo_cnt = 0;
      end else begin
        n_checks++;
        if ({hcount, vcount, x, y, hsync, vsync, video_on, line_end, frame_end, running} !==
            {e.h, e.v, e.x, e.y, e.hs, e.vs, e.vo, e.le, e.fe, e.run}) begin
          n_err++;
          $display("FAIL %s @cyc %0d: got h=%0d v=%0d x=%0d y=%0d hs=%b vs=%b vo=%b le=%b fe=%b run=%b, required h=%0d v=%0d x=%0d y=%0d hs=%b vs=%b vo=%b le=%b fe=%b run=%b",
                   e.nm, cyc, hcount, vcount, x, y, hsync, vsync, video_on, line_end, frame_end, running,
                   e.h, e.v, e.x, e.y, e.hs, e.vs, e.vo, e.le, e.fe, e.run);
        end
      end
    end
  end

  initial begin
    int e0, e2, e3, r, t;
    rst = 1'b1;
    en  = 1'b0;
    push_idle(1, "reset_1");
    push_idle(2, "reset_2");
    wait_cyc(2);
    rst = 1'b0;
    push_idle(3, "idle_en0_a");
    push_idle(4, "idle_en0_b");
    wait_cyc(4);
    en = 1'b1;
    e0 = 5;
    push_ctl(4, 2, "clear");
    // First frame: phase boundaries of both axes.
    push_run(e0, 0,          "entry");
    push_run(e0, 1,          "first_tick");
    push_run(e0, TA - 1,     "h_act_last");
    push_run(e0, TA,         "h_fp_first");
    push_run(e0, TA + TF - 1, "h_fp_last");
    push_run(e0, TA + TF,    "hsync_first");
    push_run(e0, TA + TF + TS - 1, "hsync_last");
    push_run(e0, TA + TF + TS, "h_bp_first");
    push_run(e0, HT - 1,     "line_end");
    push_run(e0, HT,         "line1_start");
    push_run(e0, HT + TA - 1, "line1_act_last");
    push_run(e0, (VA - 1) * HT + TA - 1, "last_visible");
    push_run(e0, VA * HT,    "v_fp_first");
    push_run(e0, (VA + VF) * HT - 1, "v_fp_last");
    push_run(e0, (VA + VF) * HT, "vsync_first");
    push_run(e0, (VA + VF + VS) * HT - 1, "vsync_last");
    push_run(e0, (VA + VF + VS) * HT, "v_bp_first");
    push_run(e0, FR - 1,     "frame_end");
    push_ctl(e0 + FR * DK - 1, 1, "frame_counts");
    push_run(e0, FR,         "frame2_start");
    push_run(e0, FR + 6,     "frame2_x6");
    // Drop en mid-frame; the frame must still complete.
    wait_cyc(e0 + (FR + 2 * HT + 5) * DK);
    en = 1'b0;
    push_run(e0, FR + 3 * HT, "after_en_drop");
    push_run(e0, 2 * FR - 1, "frame_end_stop");
    push_idle(e0 + 2 * FR * DK,     "stopped_a");
    push_idle(e0 + 2 * FR * DK + 1, "stopped_b");
    push_idle(e0 + 2 * FR * DK + 4, "stopped_c");
    wait_cyc(e0 + 2 * FR * DK + 4);
    en = 1'b1;
    e2 = e0 + 2 * FR * DK + 5;
    push_run(e2, 0, "restart");
    push_run(e2, 1, "restart_tick");
    // Reset in the middle of hsync with en still high.
    r = e2 + (HT + 11) * DK;
    sbq.push_back(run_exp(r, (HT + 11) * DK, "pre_rst_sync"));
    wait_cyc(r);
    rst = 1'b1;
    push_idle(r + 1, "rst_mid_sync_a");
    push_idle(r + 2, "rst_mid_sync_b");
    wait_cyc(r + 2);
    rst = 1'b0;
    e3 = r + 3;
    push_run(e3, 0,  "resume");
    push_run(e3, 1,  "resume_tick");
    push_run(e3, HT, "resume_line1");
    t = 0;
    while (sbq.size() > 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (sbq.size() > 0) begin
      n_checks++; n_err++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sbq.size());
    end
    #20;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
